// File: rtl/noc_out_port_ctrl.sv
// ---------------------------------------------------------------------------
// noc_out_port_ctrl
//
// Output-port controller for one router output. It sits behind a 4-way
// arbiter: it requests on behalf of every input that presents a packet head,
// locks the output to the granted input for a whole wormhole packet (head to
// tail), and forwards flits through a one-entry registered output stage.
//
// Handshake rule used on every flit interface of this block: a flit moves
// across an interface on a rising edge where valid and ready are both high.
// Valid never depends on ready. Ready may depend on valid, combinationally.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   per-input flit valid
//   in_flit    input flits, input i at [i*FLIT_W +: FLIT_W]
//   in_ready   per-input accept (combinational, at most one bit high)
//   arb_req    request vector to the arbiter (combinational)
//   arb_gnt    one-hot grant from the arbiter, same cycle as arb_req
//   out_valid  registered output flit valid
//   out_flit   registered output flit
//   out_ready  downstream accept
//   busy       high while the output is locked to a packet (FSM state)
//   owner      index of the locked input; meaningful only when busy=1
//   err        sticky protocol-error flag; cleared only by rst
// ---------------------------------------------------------------------------
module noc_out_port_ctrl #(
    parameter int         FLIT_W      = 34,
    parameter logic [1:0] TYPE_HEAD   = 2'b10,
    parameter logic [1:0] TYPE_BODY   = 2'b00,
    parameter logic [1:0] TYPE_TAIL   = 2'b01,
    parameter logic [1:0] TYPE_SINGLE = 2'b11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            in_valid,
    input  logic [4*FLIT_W-1:0]   in_flit,
    output logic [3:0]            in_ready,
    output logic [3:0]            arb_req,
    input  logic [3:0]            arb_gnt,
    output logic                  out_valid,
    output logic [FLIT_W-1:0]     out_flit,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [1:0]            owner,
    output logic                  err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_owner;
    logic [1:0]          w_owner_nxt;
    logic                r_first;      // next transfer is the first flit of the packet
    logic                r_out_valid;
    logic [FLIT_W-1:0]   r_out_flit;
    logic                r_err;

    logic [FLIT_W-1:0]   w_flit [4];
    logic [3:0]          w_req_idle;
    logic                w_gnt_onehot;
    logic                w_gnt_hit;
    logic [1:0]          w_gnt_idx;
    logic                w_stage_free;
    logic [FLIT_W-1:0]   w_sel_flit;
    logic [1:0]          w_sel_type;
    logic                w_sel_headlike;
    logic                w_sel_taillike;
    logic [3:0]          w_arb_req;
    logic [3:0]          w_in_ready;
    logic                w_xfer;
    logic                w_set_err;
    logic                w_grant_take;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_flit[i]     = in_flit[i*FLIT_W +: FLIT_W];
            w_req_idle[i] = in_valid[i] &&
                            ((w_flit[i][FLIT_W-1 -: 2] == TYPE_HEAD) ||
                             (w_flit[i][FLIT_W-1 -: 2] == TYPE_SINGLE));
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_gnt_onehot = (arb_gnt != 4'd0) && ((arb_gnt & (arb_gnt - 4'd1)) == 4'd0);
    assign w_gnt_hit    = (arb_gnt & w_req_idle) != 4'd0;

    always_comb begin
        w_gnt_idx = 2'd0;
        if (arb_gnt[1]) w_gnt_idx = 2'd1;
        if (arb_gnt[2]) w_gnt_idx = 2'd2;
        if (arb_gnt[3]) w_gnt_idx = 2'd3;
    end

    // The output register can take a flit if it is empty or being drained.
    assign w_stage_free   = ~r_out_valid | out_ready;
    assign w_sel_flit     = w_flit[r_owner];
    assign w_sel_type     = w_sel_flit[FLIT_W-1 -: 2];
    assign w_sel_headlike = (w_sel_type == TYPE_HEAD) || (w_sel_type == TYPE_SINGLE);
    assign w_sel_taillike = (w_sel_type == TYPE_TAIL) || (w_sel_type == TYPE_SINGLE);

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_arb_req    = 4'd0;
        w_in_ready   = 4'd0;
        w_xfer       = 1'b0;
        w_set_err    = 1'b0;
        w_grant_take = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_arb_req = w_req_idle;
                if (arb_gnt != 4'd0) begin
                    if (w_gnt_onehot && w_gnt_hit) begin
                        w_grant_take = 1'b1;
                        w_state_nxt  = ST_LOCK;
                        w_owner_nxt  = w_gnt_idx;
                    end else begin
                        w_set_err = 1'b1;
                    end
                end
            end
            ST_LOCK: begin
                w_in_ready[r_owner] = w_stage_free;
                w_xfer              = in_valid[r_owner] & w_stage_free;
                if (w_xfer) begin
                    if (w_sel_taillike) w_state_nxt = ST_IDLE;
                    // A packet must open with a head; a head mid-packet is
                    // still forwarded but flagged.
                    if (r_first && ((w_sel_type == TYPE_BODY) || (w_sel_type == TYPE_TAIL)))
                        w_set_err = 1'b1;
                    if (!r_first && w_sel_headlike)
                        w_set_err = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= 2'd0;
            r_first     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            if (w_grant_take)   r_first <= 1'b1;
            else if (w_xfer)    r_first <= 1'b0;
            if (w_set_err)      r_err   <= 1'b1;
            // Load wins over drain so a simultaneous drain+load keeps 1 flit/cycle.
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_flit  <= w_sel_flit;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign arb_req   = w_arb_req;
    assign out_valid = r_out_valid;
    assign out_flit  = r_out_flit;
    assign busy      = (r_state == ST_LOCK);
    assign owner     = r_owner;
    assign err       = r_err;

endmodule
